// File: rtl/iob_rr_merge.sv
// iob_rr_merge: round-robin merge of N native-bus masters onto one slave.
// One buffered request per master, one transaction in flight, optional timeout.
module iob_rr_merge #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_MASTERS-1:0]          m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic                          s_valid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic [DATA_W-1:0]             s_rdata_i,
  input  logic                          s_ready_i,
  output logic                          busy_o,
  output logic [$clog2(N_MASTERS)-1:0]  grant_o,
  output logic                          err_o
);

  localparam int SW = DATA_W / 8;
  localparam int GW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t               state;
  logic [GW-1:0]        ptr;
  logic [GW-1:0]        sel;
  logic [GW:0]          idx;
  logic                 found;
  logic [N_MASTERS-1:0] pending;
  logic [N_MASTERS-1:0] done;
  logic [N_MASTERS-1:0] load;
  logic                 active;
  logic                 ack;
  logic                 tmo;
  logic                 fin;

  logic [ADDR_W-1:0] buf_addr  [N_MASTERS];
  logic [DATA_W-1:0] buf_wdata [N_MASTERS];
  logic [SW-1:0]     buf_wstrb [N_MASTERS];

  // Reset gates every completion so a response during reset is dropped.
  assign active = rst_n_i && (state != IDLE);
  assign ack    = active && s_ready_i;
  assign fin    = ack || tmo;
  assign busy_o = active;
  assign err_o  = tmo;

  assign s_valid_o = rst_n_i && (state == ISSUE);
  assign s_addr_o  = s_valid_o ? buf_addr[grant_o]  : '0;
  assign s_wdata_o = s_valid_o ? buf_wdata[grant_o] : '0;
  assign s_wstrb_o = s_valid_o ? buf_wstrb[grant_o] : '0;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_m
    assign done[k] = fin && (grant_o == GW'(k));
    assign load[k] = rst_n_i && m_valid_i[k]
                   && (!pending[k] || done[k]);
    assign m_ready_o[k] = done[k];
    assign m_rdata_o[k*DATA_W +: DATA_W] =
      (done[k] && ack) ? s_rdata_i : '0;
  end

  // First pending master at or above ptr, wrapping.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = {1'b0, ptr} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_MASTERS))
        idx = idx - (GW+1)'(N_MASTERS);
      if (!found && pending[idx[GW-1:0]]) begin
        sel   = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending <= '0;
      for (int k = 0; k < N_MASTERS; k++) begin
        buf_addr[k]  <= '0;
        buf_wdata[k] <= '0;
        buf_wstrb[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
        if (load[k]) begin
          buf_addr[k]  <= m_addr_i[k*ADDR_W +: ADDR_W];
          buf_wdata[k] <= m_wdata_i[k*DATA_W +: DATA_W];
          buf_wstrb[k] <= m_wstrb_i[k*SW +: SW];
          pending[k]   <= 1'b1;
        end else if (done[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_o <= sel;
            state   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (fin) begin
            state <= IDLE;
            ptr   <= (grant_o == GW'(N_MASTERS-1))
                   ? '0 : grant_o + 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (TIMEOUT > 0) begin : g_tmo
    logic [15:0] cnt;
    // Held at zero while idle, so it starts from zero in ISSUE.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i || state == IDLE) cnt <= '0;
      else                           cnt <= cnt + 16'd1;
    end
    assign tmo = active && !s_ready_i
              && (cnt == 16'(TIMEOUT));
  end else begin : g_no_tmo
    assign tmo = 1'b0;
  end

endmodule

// File: tb/tb_iob_rr_merge.sv
// tb_iob_rr_merge: directed checks of arbitration, buffering,
// timeout and reset on three differently parameterised instances.
module tb_iob_rr_merge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  logic [1:0]  a_valid, a_ready;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic [7:0]  a_wstrb;
  logic        a_s_valid, a_s_ready, a_busy, a_err;
  logic [31:0] a_s_addr, a_s_wdata, a_s_rdata;
  logic [3:0]  a_s_wstrb;
  logic [0:0]  a_grant;

  logic [2:0]  b_valid, b_ready;
  logic [95:0] b_addr, b_wdata, b_rdata;
  logic [11:0] b_wstrb;
  logic        b_s_valid, b_s_ready, b_busy, b_err;
  logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;
  logic [3:0]  b_s_wstrb;
  logic [1:0]  b_grant;

  logic [1:0]  c_valid, c_ready;
  logic [63:0] c_addr, c_wdata, c_rdata;
  logic [7:0]  c_wstrb;
  logic        c_s_valid, c_s_ready, c_busy, c_err;
  logic [31:0] c_s_addr, c_s_wdata, c_s_rdata;
  logic [3:0]  c_s_wstrb;
  logic [0:0]  c_grant;

  iob_rr_merge #(.N_MASTERS(2)) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_valid_i(a_valid), .m_addr_i(a_addr),
    .m_wdata_i(a_wdata), .m_wstrb_i(a_wstrb),
    .m_rdata_o(a_rdata), .m_ready_o(a_ready),
    .s_valid_o(a_s_valid), .s_addr_o(a_s_addr),
    .s_wdata_o(a_s_wdata), .s_wstrb_o(a_s_wstrb),
    .s_rdata_i(a_s_rdata), .s_ready_i(a_s_ready),
    .busy_o(a_busy), .grant_o(a_grant), .err_o(a_err)
  );

  iob_rr_merge #(.N_MASTERS(3)) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_valid_i(b_valid), .m_addr_i(b_addr),
    .m_wdata_i(b_wdata), .m_wstrb_i(b_wstrb),
    .m_rdata_o(b_rdata), .m_ready_o(b_ready),
    .s_valid_o(b_s_valid), .s_addr_o(b_s_addr),
    .s_wdata_o(b_s_wdata), .s_wstrb_o(b_s_wstrb),
    .s_rdata_i(b_s_rdata), .s_ready_i(b_s_ready),
    .busy_o(b_busy), .grant_o(b_grant), .err_o(b_err)
  );

  iob_rr_merge #(.N_MASTERS(2), .TIMEOUT(5)) u_c (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_valid_i(c_valid), .m_addr_i(c_addr),
    .m_wdata_i(c_wdata), .m_wstrb_i(c_wstrb),
    .m_rdata_o(c_rdata), .m_ready_o(c_ready),
    .s_valid_o(c_s_valid), .s_addr_o(c_s_addr),
    .s_wdata_o(c_s_wdata), .s_wstrb_o(c_s_wstrb),
    .s_rdata_i(c_s_rdata), .s_ready_i(c_s_ready),
    .busy_o(c_busy), .grant_o(c_grant), .err_o(c_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    a_s_rdata = '0; a_s_ready = 1'b0;
    b_valid = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    b_s_rdata = '0; b_s_ready = 1'b0;
    c_valid = '0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    c_s_rdata = '0; c_s_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [134:0] oa, ob, oc;
    clear_inputs();
    rst_n = 1'b0;
    a_s_ready = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        tick();
        rst_n = 1'b1;
        a_s_ready = 1'b0;
      end
      @(negedge clk);
      oa = {a_s_valid, a_busy, a_ready, a_err, a_grant,
            a_s_addr, a_s_wdata, a_s_wstrb, a_rdata};
      ob = 135'({b_s_valid, b_busy, b_ready, b_err, b_grant,
            b_s_addr, b_rdata});
      oc = {c_s_valid, c_busy, c_ready, c_err, c_grant,
            c_s_addr, c_s_wdata, c_s_wstrb, c_rdata};
      vecs++;
      if (oa !== '0) begin
        errs++;
        $display("FAIL reset_a c=%0d got %h want 0", c, oa);
      end
      vecs++;
      if (ob !== '0) begin
        errs++;
        $display("FAIL reset_b c=%0d got %h want 0", c, ob);
      end
      vecs++;
      if (oc !== '0) begin
        errs++;
        $display("FAIL reset_c c=%0d got %h want 0", c, oc);
      end
    end
  endtask

  task automatic test_single();
    logic [4:0]   oc, ec;
    logic [131:0] od, ed;
    for (int c = 0; c < 6; c++) begin
      tick();
      a_valid = '0;
      a_s_ready = 1'b0;
      if (c == 0) begin
        a_valid = 2'b01;
        a_addr[31:0] = 32'h10;
      end
      if (c == 4) begin
        a_s_ready = 1'b1;
        a_s_rdata = 32'hCAFE;
      end
      @(negedge clk);
      oc = {a_s_valid, a_busy, a_ready, a_err};
      ec = {c == 2, c >= 2 && c <= 4,
            (c == 4) ? 2'b01 : 2'b00, 1'b0};
      od = {a_s_addr, a_s_wdata, a_s_wstrb, a_rdata};
      ed = '0;
      if (c == 2) ed[131:100] = 32'h10;
      if (c == 4) ed[31:0] = 32'hCAFE;
      vecs++;
      if (oc !== ec) begin
        errs++;
        $display("FAIL single_ctl c=%0d got %b want %b", c, oc, ec);
      end
      vecs++;
      if (od !== ed) begin
        errs++;
        $display("FAIL single_dat c=%0d got %h want %h", c, od, ed);
      end
    end
  endtask

  task automatic test_order();
    logic [6:0]   oc, ec;
    logic [127:0] od, ed;
    logic [95:0]  er;
    logic         iss;
    int           k;
    for (int c = 0; c < 8; c++) begin
      tick();
      b_valid = '0;
      b_s_ready = 1'b0;
      iss = (c == 2 || c == 4 || c == 6);
      k = c / 2 - 1;
      if (c == 0) begin
        b_valid = 3'b111;
        b_addr = {32'h300, 32'h200, 32'h100};
      end
      if (iss) begin
        b_s_ready = 1'b1;
        b_s_rdata = 32'(32'hA0 + c);
      end
      @(negedge clk);
      er = '0;
      if (iss) er[k*32 +: 32] = 32'(32'hA0 + c);
      oc = {b_s_valid, b_busy, b_ready, b_err, b_grant};
      ec = {iss, iss, iss ? 3'(1 << k) : 3'b000, 1'b0,
            (c < 2) ? 2'd0 : 2'(k)};
      od = {b_s_addr, b_rdata};
      ed = {iss ? 32'(32'h100 * (k + 1)) : 32'h0, er};
      vecs++;
      if (oc !== ec) begin
        errs++;
        $display("FAIL order_ctl c=%0d got %b want %b", c, oc, ec);
      end
      vecs++;
      if (od !== ed) begin
        errs++;
        $display("FAIL order_dat c=%0d got %h want %h", c, od, ed);
      end
    end
  endtask

  task automatic test_fair();
    logic [5:0]  oc, ec;
    logic [31:0] ea;
    logic        iss;
    int          g;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      a_valid = '0;
      a_s_ready = 1'b0;
      iss = (c >= 2) && (c % 2 == 0);
      g = (c < 2) ? 0 : (c / 2 - 1) % 2;
      if (c == 0) begin
        a_valid = 2'b11;
        a_addr = {32'h2000, 32'h1000};
      end
      if (iss) begin
        a_s_ready = 1'b1;
        a_valid[g] = 1'b1;
        a_addr[g*32 +: 32] = 32'(32'h1000 * (g + 1) + c);
      end
      @(negedge clk);
      ea = !iss ? 32'h0
         : (c <= 4) ? 32'(32'h1000 * (g + 1))
         : 32'(32'h1000 * (g + 1) + c - 4);
      oc = {a_s_valid, a_busy, a_ready, a_err, a_grant};
      ec = {iss, iss, iss ? 2'(1 << g) : 2'b00, 1'b0, 1'(g)};
      vecs++;
      if (oc !== ec) begin
        errs++;
        $display("FAIL fair_ctl c=%0d got %b want %b", c, oc, ec);
      end
      vecs++;
      if (a_s_addr !== ea) begin
        errs++;
        $display("FAIL fair_addr c=%0d got %h want %h",
                 c, a_s_addr, ea);
      end
    end
  endtask

  task automatic test_ignore();
    logic [5:0]   oc, ec;
    logic [131:0] od, ed;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      tick();
      a_valid = '0;
      a_s_ready = 1'b0;
      unique case (c)
        0: begin
          a_valid = 2'b01; a_addr[31:0] = 32'h40;
          a_wdata[31:0] = 32'h11; a_wstrb[3:0] = 4'hF;
        end
        1: begin
          a_valid = 2'b01; a_addr[31:0] = 32'h44;
          a_wdata[31:0] = 32'h33; a_wstrb[3:0] = 4'h3;
        end
        2: begin a_valid = 2'b01; a_addr[31:0] = 32'h48; end
        3: begin a_valid = 2'b01; a_addr[31:0] = 32'h4C; end
        4: begin
          a_s_ready = 1'b1; a_s_rdata = 32'h77;
          a_valid = 2'b01; a_addr[31:0] = 32'h50;
          a_wdata[31:0] = 32'h22; a_wstrb[3:0] = 4'h0;
        end
        6: begin a_s_ready = 1'b1; a_s_rdata = 32'h99; end
        7, 8: begin a_s_ready = 1'b1; a_s_rdata = 32'h55; end
        default: ;
      endcase
      @(negedge clk);
      oc = {a_s_valid, a_busy, a_ready, a_err, a_grant};
      ec = {c == 2 || c == 6, (c >= 2 && c <= 4) || c == 6,
            (c == 4 || c == 6) ? 2'b01 : 2'b00, 2'b00};
      od = {a_s_addr, a_s_wdata, a_s_wstrb, a_rdata};
      ed = '0;
      if (c == 2) ed = {32'h40, 32'h11, 4'hF, 64'h0};
      if (c == 4) ed = {32'h0, 32'h0, 4'h0, 64'h77};
      if (c == 6) ed = {32'h50, 32'h22, 4'h0, 64'h99};
      vecs++;
      if (oc !== ec) begin
        errs++;
        $display("FAIL ignore_ctl c=%0d got %b want %b", c, oc, ec);
      end
      vecs++;
      if (od !== ed) begin
        errs++;
        $display("FAIL ignore_dat c=%0d got %h want %h", c, od, ed);
      end
    end
  endtask

  task automatic test_reset_wait();
    logic [5:0]   oc, ec;
    logic [131:0] od;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      tick();
      a_valid = '0;
      a_s_ready = 1'b0;
      if (c == 0) begin
        a_valid = 2'b01;
        a_addr[31:0] = 32'h80;
      end
      if (c == 4) begin
        rst_n = 1'b0;
        a_s_ready = 1'b1;
        a_s_rdata = 32'h1234;
      end
      if (c == 5) begin
        rst_n = 1'b1;
        a_s_ready = 1'b1;
      end
      @(negedge clk);
      if (c == 4) begin
        vecs++;
        if ({a_ready, a_rdata} !== '0) begin
          errs++;
          $display("FAIL rstwait_ack c=%0d got %h want 0",
                   c, {a_ready, a_rdata});
        end
      end else begin
        oc = {a_s_valid, a_busy, a_ready, a_err, a_grant};
        ec = {c == 2, c == 2 || c == 3, 4'b0000};
        od = {a_s_addr, a_s_wdata, a_s_wstrb, a_rdata};
        vecs++;
        if (oc !== ec) begin
          errs++;
          $display("FAIL rstwait_ctl c=%0d got %b want %b",
                   c, oc, ec);
        end
        if (c >= 5) begin
          vecs++;
          if (od !== '0) begin
            errs++;
            $display("FAIL rstwait_dat c=%0d got %h want 0", c, od);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0]  oc, ec;
    logic [95:0] od, ed;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      c_valid = '0;
      c_s_ready = 1'b0;
      c_s_rdata = 32'hDEAD;
      if (c == 0) begin
        c_valid = 2'b10;
        c_addr[63:32] = 32'h600;
      end
      if (c == 8) c_s_ready = 1'b1;
      @(negedge clk);
      oc = {c_s_valid, c_busy, c_ready, c_err, c_grant};
      ec = {c == 2, c >= 2 && c <= 7,
            (c == 7) ? 2'b10 : 2'b00, c == 7, c >= 2};
      od = {c_s_addr, c_rdata};
      ed = {(c == 2) ? 32'h600 : 32'h0, 64'h0};
      vecs++;
      if (oc !== ec) begin
        errs++;
        $display("FAIL timeout_ctl c=%0d got %b want %b", c, oc, ec);
      end
      vecs++;
      if (od !== ed) begin
        errs++;
        $display("FAIL timeout_dat c=%0d got %h want %h", c, od, ed);
      end
    end
  endtask

  task automatic test_timeout_race();
    logic [5:0]  oc, ec;
    logic [95:0] od, ed;
    for (int c = 0; c < 9; c++) begin
      tick();
      c_valid = '0;
      c_s_ready = 1'b0;
      if (c == 0) begin
        c_valid = 2'b01;
        c_addr[31:0] = 32'h700;
      end
      if (c == 7) begin
        c_s_ready = 1'b1;
        c_s_rdata = 32'hBEEF;
      end
      @(negedge clk);
      oc = {c_s_valid, c_busy, c_ready, c_err, c_grant};
      ec = {c == 2, c >= 2 && c <= 7,
            (c == 7) ? 2'b01 : 2'b00, 1'b0, c < 2};
      od = {c_s_addr, c_rdata};
      ed = '0;
      if (c == 2) ed[95:64] = 32'h700;
      if (c == 7) ed[31:0] = 32'hBEEF;
      vecs++;
      if (oc !== ec) begin
        errs++;
        $display("FAIL race_ctl c=%0d got %b want %b", c, oc, ec);
      end
      vecs++;
      if (od !== ed) begin
        errs++;
        $display("FAIL race_dat c=%0d got %h want %h", c, od, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_fair();
    test_ignore();
    test_reset_wait();
    test_timeout();
    test_timeout_race();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
